// File: rtl/exe_mem_unit.sv
// Execute stage of the 5-stage MIPS pipeline: EX forwarding muxes, ALU with
// flags, the EXE/MEM pipeline register, and the ID-stage branch-operand
// forwarding detector that compares against the registered MEM-stage writer.
module exe_mem_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] read_data1_reg,
  input  logic [W-1:0] read_data2_reg,
  input  logic [W-1:0] inst_extended,
  input  logic [4:0]   shamnt,
  input  logic         AluSrc1,
  input  logic         AluSrc,
  input  logic [3:0]   AluOperation,
  input  logic [1:0]   ForwardA,
  input  logic [1:0]   ForwardB,
  input  logic [W-1:0] result_WB,
  input  logic [4:0]   write_reg_in,
  input  logic         MemtoRegIn,
  input  logic         MemWriteIn,
  input  logic         MemReadIn,
  input  logic         DatacIn,
  input  logic         RegwriteIn,
  input  logic [W-1:0] pc_in,
  input  logic [4:0]   rs_id,
  input  logic [4:0]   rt_id,
  output logic         zero_flag,
  output logic         overflow,
  output logic [W-1:0] alu_result,
  output logic [W-1:0] write_data_out,
  output logic [4:0]   write_reg_mem,
  output logic [W-1:0] alu_result_mem,
  output logic [W-1:0] write_data_mem,
  output logic [W-1:0] pc_mem,
  output logic         MemtoReg_mem,
  output logic         MemWrite_mem,
  output logic         MemRead_mem,
  output logic         Datac_mem,
  output logic         Regwrite_mem,
  output logic         fw_rs,
  output logic         fw_rt
);

  logic        [W-1:0] fwd_a;
  logic        [W-1:0] fwd_b;
  logic signed [W-1:0] op_a;
  logic signed [W-1:0] op_b;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] diff;

  // Signed overflow of A+B: same operand signs, result sign flipped.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow of A-B: operand signs differ, result sign differs from A.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // EX forwarding: pick register value, WB result, or our own MEM register.
  always_comb begin
    unique case (ForwardA)
      2'b01:   fwd_a = result_WB;
      2'b10:   fwd_a = alu_result_mem;
      default: fwd_a = read_data1_reg;
    endcase
    unique case (ForwardB)
      2'b01:   fwd_b = result_WB;
      2'b10:   fwd_b = alu_result_mem;
      default: fwd_b = read_data2_reg;
    endcase
  end

  assign op_a           = AluSrc1 ? {{(W-5){1'b0}}, shamnt} : fwd_a;
  assign op_b           = AluSrc ? inst_extended : fwd_b;
  assign write_data_out = fwd_b;
  assign sum            = op_a + op_b;
  assign diff           = op_a - op_b;

  // ALU: result and overflow; overflow only meaningful for ADD/SUB.
  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    case (AluOperation)
      4'b0000: alu_result = op_a & op_b;
      4'b0001: alu_result = op_a | op_b;
      4'b0010: begin
        alu_result = sum;
        overflow   = add_ovf(op_a[W-1], op_b[W-1], sum[W-1]);
      end
      4'b0011: alu_result = op_a ^ op_b;
      4'b0100: alu_result = ~(op_a | op_b);
      4'b0110: begin
        alu_result = diff;
        overflow   = sub_ovf(op_a[W-1], op_b[W-1], diff[W-1]);
      end
      4'b0111: alu_result = {{(W-1){1'b0}}, (op_a < op_b)};
      4'b1100: alu_result = {{(W-1){1'b0}}, ($unsigned(op_a) < $unsigned(op_b))};
      4'b1000: alu_result = op_b << op_a[4:0];
      4'b1001: alu_result = $unsigned(op_b) >> op_a[4:0];
      4'b1010: alu_result = op_b >>> op_a[4:0];
      4'b1011: alu_result = op_b << 16;
      default: alu_result = '0;
    endcase
  end

  assign zero_flag = (alu_result == '0);

  // EXE/MEM pipeline register: one-cycle latency, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_reg_mem  <= '0;
      alu_result_mem <= '0;
      write_data_mem <= '0;
      pc_mem         <= '0;
      MemtoReg_mem   <= 1'b0;
      MemWrite_mem   <= 1'b0;
      MemRead_mem    <= 1'b0;
      Datac_mem      <= 1'b0;
      Regwrite_mem   <= 1'b0;
    end else begin
      write_reg_mem  <= write_reg_in;
      alu_result_mem <= alu_result;
      write_data_mem <= write_data_out;
      pc_mem         <= pc_in;
      MemtoReg_mem   <= MemtoRegIn;
      MemWrite_mem   <= MemWriteIn;
      MemRead_mem    <= MemReadIn;
      Datac_mem      <= DatacIn;
      Regwrite_mem   <= RegwriteIn;
    end
  end

  // Branch operands in ID come from the MEM-stage result; $0 never matches.
  assign fw_rs = Regwrite_mem && (write_reg_mem != 5'd0) && (write_reg_mem == rs_id);
  assign fw_rt = Regwrite_mem && (write_reg_mem != 5'd0) && (write_reg_mem == rt_id);

endmodule

// File: tb/tb_exe_mem_unit.sv
// Scoreboard bench for exe_mem_unit: stimulus pushes expected values tagged
// with the cycle they must appear in; a negedge monitor pops and compares.
module tb_exe_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] read_data1_reg, read_data2_reg, inst_extended, result_WB, pc_in;
  logic [4:0]  shamnt, write_reg_in, rs_id, rt_id;
  logic        AluSrc1, AluSrc;
  logic [3:0]  AluOperation;
  logic [1:0]  ForwardA, ForwardB;
  logic        MemtoRegIn, MemWriteIn, MemReadIn, DatacIn, RegwriteIn;
  logic        zero_flag, overflow;
  logic [31:0] alu_result, write_data_out, alu_result_mem, write_data_mem, pc_mem;
  logic [4:0]  write_reg_mem;
  logic        MemtoReg_mem, MemWrite_mem, MemRead_mem, Datac_mem, Regwrite_mem;
  logic        fw_rs, fw_rt;

  exe_mem_unit #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .read_data1_reg(read_data1_reg), .read_data2_reg(read_data2_reg),
    .inst_extended(inst_extended), .shamnt(shamnt),
    .AluSrc1(AluSrc1), .AluSrc(AluSrc), .AluOperation(AluOperation),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .result_WB(result_WB),
    .write_reg_in(write_reg_in), .MemtoRegIn(MemtoRegIn), .MemWriteIn(MemWriteIn),
    .MemReadIn(MemReadIn), .DatacIn(DatacIn), .RegwriteIn(RegwriteIn),
    .pc_in(pc_in), .rs_id(rs_id), .rt_id(rt_id),
    .zero_flag(zero_flag), .overflow(overflow), .alu_result(alu_result),
    .write_data_out(write_data_out), .write_reg_mem(write_reg_mem),
    .alu_result_mem(alu_result_mem), .write_data_mem(write_data_mem),
    .pc_mem(pc_mem), .MemtoReg_mem(MemtoReg_mem), .MemWrite_mem(MemWrite_mem),
    .MemRead_mem(MemRead_mem), .Datac_mem(Datac_mem), .Regwrite_mem(Regwrite_mem),
    .fw_rs(fw_rs), .fw_rt(fw_rt)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      0:  return alu_result;
      1:  return {31'd0, zero_flag};
      2:  return {31'd0, overflow};
      3:  return write_data_out;
      4:  return alu_result_mem;
      5:  return {27'd0, write_reg_mem};
      6:  return {31'd0, Regwrite_mem};
      7:  return {31'd0, fw_rs};
      8:  return {31'd0, fw_rt};
      9:  return write_data_mem;
      10: return pc_mem;
      11: return {31'd0, MemWrite_mem};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Push an expectation due 'dly' cycles from now (0 = combinational now).
  task automatic expect_at(input int sel, input string name, input logic [31:0] val, input int dly);
    exp_t e;
    e.cyc = cycle + dly; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: on every negedge, compare all expectations due this cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cycle) begin
        logic [31:0] act;
        act = get_sig(q[i].sel);
        n_checks++;
        if (act === q[i].val) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h",
                      q[i].name, cycle, act, q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset edge with nonzero inputs everywhere
    rst = 1'b0;
    read_data1_reg = 32'h1111_1111; read_data2_reg = 32'h2222_2222;
    inst_extended = 32'h33; shamnt = 5'd3; AluSrc1 = 1'b0; AluSrc = 1'b0;
    AluOperation = 4'b0010; ForwardA = 2'b00; ForwardB = 2'b00;
    result_WB = 32'h44; write_reg_in = 5'd8; pc_in = 32'h100;
    MemtoRegIn = 1'b1; MemWriteIn = 1'b1; MemReadIn = 1'b1; DatacIn = 1'b1;
    RegwriteIn = 1'b1; rs_id = 5'd8; rt_id = 5'd8;
    step();
    expect_at(4, "rst_alu_result_mem", 32'd0, 0);
    expect_at(5, "rst_write_reg_mem", 32'd0, 0);
    expect_at(6, "rst_regwrite_mem", 32'd0, 0);
    expect_at(7, "rst_fw_rs", 32'd0, 0);
    expect_at(8, "rst_fw_rt", 32'd0, 0);

    // ADD 5+7, then latch into EXE/MEM
    rst = 1'b1;
    read_data1_reg = 32'd5; read_data2_reg = 32'd7; AluOperation = 4'b0010;
    write_reg_in = 5'd8; RegwriteIn = 1'b1; pc_in = 32'h104; MemWriteIn = 1'b1;
    expect_at(0, "add_result", 32'd12, 0);
    expect_at(2, "add_ovf", 32'd0, 0);
    expect_at(4, "add_mem_result", 32'd12, 1);
    expect_at(5, "add_mem_wreg", 32'd8, 1);
    expect_at(6, "add_mem_regwrite", 32'd1, 1);
    expect_at(9, "add_mem_wdata", 32'd7, 1);
    expect_at(10, "add_mem_pc", 32'h104, 1);
    expect_at(11, "add_mem_memwrite", 32'd1, 1);
    step();

    // SUB using the MEM-forwarded 12 as A: 12-3
    ForwardA = 2'b10; read_data1_reg = 32'd0; read_data2_reg = 32'd3;
    AluOperation = 4'b0110; MemWriteIn = 1'b0;
    expect_at(0, "fwd_mem_sub", 32'd9, 0);
    expect_at(4, "sub_mem_result", 32'd9, 1);
    step();

    // ForwardB from WB feeds write_data_out
    ForwardA = 2'b00; ForwardB = 2'b01; result_WB = 32'h20; AluOperation = 4'b0001;
    read_data1_reg = 32'h1;
    expect_at(3, "fwd_wb_wdata", 32'h20, 0);
    expect_at(0, "or_fwd_wb", 32'h21, 0);
    step();

    // ADD signed overflow
    ForwardB = 2'b00; AluOperation = 4'b0010;
    read_data1_reg = 32'h7FFF_FFFF; read_data2_reg = 32'd1;
    expect_at(0, "add_ovf_result", 32'h8000_0000, 0);
    expect_at(2, "add_ovf_flag", 32'd1, 0);
    expect_at(1, "add_ovf_zero", 32'd0, 0);
    step();

    // SUB 4-4: zero, no overflow
    AluOperation = 4'b0110; read_data1_reg = 32'd4; read_data2_reg = 32'd4;
    expect_at(1, "sub_zero", 32'd1, 0);
    expect_at(2, "sub_zero_ovf", 32'd0, 0);
    step();

    // SUB signed overflow: 0x80000000 - 1
    read_data1_reg = 32'h8000_0000; read_data2_reg = 32'd1;
    expect_at(0, "sub_ovf_result", 32'h7FFF_FFFF, 0);
    expect_at(2, "sub_ovf_flag", 32'd1, 0);
    step();

    // Shifts by shamnt=4
    AluSrc1 = 1'b1; shamnt = 5'd4; read_data2_reg = 32'h8000_0000;
    AluOperation = 4'b1010;
    expect_at(0, "sra", 32'hF800_0000, 0);
    step();
    AluOperation = 4'b1001;
    expect_at(0, "srl", 32'h0800_0000, 0);
    step();
    AluOperation = 4'b1000; read_data2_reg = 32'h0000_00F1;
    expect_at(0, "sll", 32'h0000_0F10, 0);
    step();

    // Signed vs unsigned compare: -1 < 1
    AluSrc1 = 1'b0; read_data1_reg = 32'hFFFF_FFFF; read_data2_reg = 32'd1;
    AluOperation = 4'b0111;
    expect_at(0, "slt", 32'd1, 0);
    step();
    AluOperation = 4'b1100;
    expect_at(0, "sltu", 32'd0, 0);
    step();

    // LUI from immediate; unused op code gives 0
    AluSrc = 1'b1; inst_extended = 32'h0000_1234; AluOperation = 4'b1011;
    expect_at(0, "lui", 32'h1234_0000, 0);
    step();
    AluSrc = 1'b0; AluOperation = 4'b0101;
    expect_at(0, "undef_op", 32'd0, 0);
    expect_at(1, "undef_zero", 32'd1, 0);
    // Write to $9 lands in MEM next cycle
    RegwriteIn = 1'b1; write_reg_in = 5'd9;
    step();

    // Branch forwarding from $9
    rs_id = 5'd9; rt_id = 5'd9;
    expect_at(7, "bfw_rs_match", 32'd1, 0);
    expect_at(8, "bfw_rt_match", 32'd1, 0);
    write_reg_in = 5'd0;
    step();
    expect_at(7, "bfw_rs_r0", 32'd0, 0);
    expect_at(8, "bfw_rt_r0", 32'd0, 0);
    RegwriteIn = 1'b0; write_reg_in = 5'd9;
    step();
    expect_at(7, "bfw_rs_norw", 32'd0, 0);
    expect_at(8, "bfw_rt_norw", 32'd0, 0);
    RegwriteIn = 1'b1;
    step();
    rt_id = 5'd5;
    expect_at(7, "bfw_rs_only", 32'd1, 0);
    expect_at(8, "bfw_rt_other", 32'd0, 0);

    // Reset mid-operation: MEM register clears, MEM forward source reads 0
    rst = 1'b0;
    expect_at(4, "midrst_result_mem", 32'd0, 1);
    expect_at(6, "midrst_regwrite", 32'd0, 1);
    expect_at(7, "midrst_fw_rs", 32'd0, 1);
    step();
    ForwardA = 2'b10; ForwardB = 2'b00; read_data2_reg = 32'd5; AluOperation = 4'b0001;
    expect_at(0, "midrst_fwd_mem", 32'd5, 0);
    step();

    // Drain, bounded
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exe_mem_unit.md
Name: exe_mem_unit

Overview:
- Execute stage of the 5-stage MIPS pipeline, fused with the EXE/MEM pipeline register and the ID-stage branch-operand forwarding detector.
- Selects ALU operands through the EX forwarding muxes and computes the ALU result and flags.
- Registers the result and the MEM/WB control signals into the EXE/MEM register.
- Tells the ID stage when a branch comparison operand must come from the registered MEM-stage ALU result.

Parameters:
- W, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- read_data1_reg  in  W  rs value from ID/EXE.
- read_data2_reg  in  W  rt value from ID/EXE.
- inst_extended  in  W  sign-extended immediate.
- shamnt  in  5  shift amount.
- AluSrc1  in  1  operand A select: 1 = {27'b0, shamnt}, 0 = forwarded A.
- AluSrc  in  1  operand B select: 1 = inst_extended, 0 = forwarded B.
- AluOperation  in  4  ALU op code.
- ForwardA, ForwardB  in  2 each  00 = register value, 01 = result_WB, 10 = alu_result_mem, 11 = register value.
- result_WB  in  W  write-back result.
- write_reg_in  in  5  destination register from EXE.
- MemtoRegIn, MemWriteIn, MemReadIn, DatacIn, RegwriteIn  in  1 each  control bits from EXE.
- pc_in  in  W  PC+4 of the instruction.
- rs_id, rt_id  in  5 each  IF/ID source register fields.
- zero_flag  out  1  combinational; alu_result == 0.
- overflow  out  1  combinational signed overflow.
- alu_result  out  W  combinational EXE result.
- write_data_out  out  W  combinational forwarded B, taken before the AluSrc mux.
- write_reg_mem  out  5  registered destination register.
- alu_result_mem  out  W  registered ALU result.
- write_data_mem  out  W  registered store data.
- pc_mem  out  W  registered PC+4.
- MemtoReg_mem, MemWrite_mem, MemRead_mem, Datac_mem, Regwrite_mem  out  1 each  registered control bits.
- fw_rs, fw_rt  out  1 each  combinational branch-operand forwarding.

Behaviour:
- Forwarding: fwdA is selected from read_data1_reg and fwdB from read_data2_reg per ForwardA/ForwardB. The MEM source is the module's own alu_result_mem register output.
- Operands: A = AluSrc1 ? zero-extended shamnt : fwdA. B = AluSrc ? inst_extended : fwdB. write_data_out = fwdB.
- ALU ops:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR.
  - 0110 SUB (A-B); 0111 SLT, signed, result 1/0; 1100 SLTU, unsigned.
  - 1000 SLL = B << A[4:0]; 1001 SRL = B >> A[4:0], logical; 1010 SRA = B >>> A[4:0], arithmetic.
  - 1011 LUI = B << 16.
  - Any other code gives result 0.
- overflow is asserted only for ADD/SUB on signed overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - Overflow does not suppress any write.
- zero_flag reflects alu_result for every op.
- EXE/MEM register:
  - On each rising clk with rst=1, latches alu_result, write_data_out, write_reg_in, pc_in and the five control bits.
  - No enable and no flush.
  - Latency is exactly 1 cycle.
- Reset: on a rising clk with rst=0, all registered outputs become 0. Reset wins over any input.
- Reset mid-operation: registered outputs read 0 on the next edge, so the MEM forward source reads 0 while reset is held.
- Branch forwarding (combinational, from registered values):
  - fw_rs = Regwrite_mem && write_reg_mem != 0 && write_reg_mem == rs_id.
  - fw_rt uses the same rule with rt_id.
  - Both are asserted together when rs_id == rt_id.
- Register $0 is never a forwarding match.
- MEM-over-WB priority for EX forwarding is the caller's responsibility (ForwardA/ForwardB arrive already encoded).

Test Plan:
- Reset: hold rst=0 one edge with nonzero inputs -> alu_result_mem=0, write_reg_mem=0, Regwrite_mem=0; fw_rs=fw_rt=0.
- ADD then latch: read_data1=5, read_data2=7, AluOperation=0010, ForwardA=ForwardB=00, RegwriteIn=1, write_reg_in=8 -> alu_result=12 combinationally; after one edge alu_result_mem=12, write_reg_mem=8.
- Forwarding (MEM path): previous result 12 registered, ForwardA=10, read_data1=0, read_data2=3, SUB -> alu_result=9.
  - ForwardB=01 with result_WB=0x20 -> write_data_out=0x20.
- Overflow and zero:
  - ADD 0x7FFFFFFF+1 -> alu_result=0x80000000, overflow=1.
  - SUB 4-4 -> zero_flag=1, overflow=0.
- Shifts and compares (AluSrc1=1, shamnt=4):
  - SRA on 0x80000000 -> 0xF8000000.
  - SRL on the same operand -> 0x08000000.
  - SLT -1<1 -> 1; SLTU on the same operands -> 0.
- Branch forwarding: Regwrite_mem=1, write_reg_mem=9, rs_id=9, rt_id=9 -> fw_rs=fw_rt=1.
  - With write_reg_mem=0 -> both 0.
  - With Regwrite_mem=0 -> both 0.
